// File: rtl/pc_source_unit.sv
// Program counter with a selectable next-PC source, stall buffering of one redirect,
// exception override, bad-selector flagging and a saturating redirect counter.
module pc_source_unit #(
   parameter int                DATA_W     = 32,
   parameter int                NUM_SRC    = 5,
   parameter int                SEL_W      = 3,
   parameter logic [DATA_W-1:0] RESET_PC   = '0,
   parameter logic [DATA_W-1:0] EXC_VECTOR = 32'h000000FC,
   parameter int                CNT_W      = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [SEL_W-1:0]          selector,
   input  logic [NUM_SRC*DATA_W-1:0] data_in,
   input  logic                      pc_write,
   input  logic                      pc_write_cond,
   input  logic                      cond_true,
   input  logic                      stall,
   input  logic                      exception,
   output logic [DATA_W-1:0]         pc_out,
   output logic [DATA_W-1:0]         pc_next,
   output logic                      pending,
   output logic                      sel_error,
   output logic                      misaligned,
   output logic [CNT_W-1:0]          redirect_count
);

   typedef enum logic {IDLE, PEND} state_t;

   localparam logic [SEL_W:0] NUM_SRC_EXT = (SEL_W+1)'(NUM_SRC);

   state_t              r_state;
   state_t              w_stateNext;
   logic [DATA_W-1:0]   r_pc;
   logic [DATA_W-1:0]   r_buf;
   logic [DATA_W-1:0]   w_bufNext;
   logic [DATA_W-1:0]   w_loadVal;
   logic                w_load;
   logic [CNT_W-1:0]    r_count;
   logic                r_selError;
   logic [DATA_W-1:0]   w_srcSel;
   logic                w_selValid;
   logic                w_upd;
   logic                w_updValid;

   always_comb begin
      w_srcSel = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (selector == SEL_W'(k)) begin
            w_srcSel = data_in[k*DATA_W +: DATA_W];
         end
      end
   end

   assign w_selValid = ({1'b0, selector} < NUM_SRC_EXT);
   assign w_upd      = pc_write | (pc_write_cond & cond_true);
   assign w_updValid = w_upd & w_selValid;
   assign pc_next    = w_selValid ? w_srcSel : r_pc;

   // An invalid-selector request is treated as no request for the target path.
   always_comb begin
      w_stateNext = r_state;
      w_bufNext   = r_buf;
      w_load      = 1'b0;
      w_loadVal   = r_pc;
      if (exception) begin
         w_load      = 1'b1;
         w_loadVal   = EXC_VECTOR;
         w_bufNext   = '0;
         w_stateNext = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_updValid) begin
                  if (stall) begin
                     w_bufNext   = pc_next;
                     w_stateNext = PEND;
                  end else begin
                     w_load    = 1'b1;
                     w_loadVal = pc_next;
                  end
               end
            end
            PEND: begin
               if (stall) begin
                  if (w_updValid) begin
                     w_bufNext = pc_next;
                  end
               end else begin
                  w_load      = 1'b1;
                  w_loadVal   = w_updValid ? pc_next : r_buf;
                  w_bufNext   = '0;
                  w_stateNext = IDLE;
               end
            end
            default: w_stateNext = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_buf      <= '0;
         r_pc       <= RESET_PC;
         r_count    <= '0;
         r_selError <= 1'b0;
      end else begin
         r_state    <= w_stateNext;
         r_buf      <= w_bufNext;
         r_selError <= w_upd & ~w_selValid;
         if (w_load) begin
            r_pc <= w_loadVal;
            if (r_count != '1) begin
               r_count <= r_count + CNT_W'(1);
            end
         end
      end
   end

   assign pc_out         = r_pc;
   assign pending        = (r_state == PEND);
   assign sel_error      = r_selError;
   assign misaligned     = |r_pc[1:0];
   assign redirect_count = r_count;

endmodule

// File: doc/pc_source_unit.md
PC_SOURCE_UNIT -- requirements
Module: pc_source_unit

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning PC and source width in bits.
REQ-002 The block SHALL have parameter NUM_SRC, default 5, meaning number of PC source inputs (2..8).
REQ-003 The block SHALL have parameter SEL_W, default 3, meaning selector width; 2**SEL_W >= NUM_SRC.
REQ-004 The block SHALL have parameter RESET_PC, default 0, meaning PC value after reset.
REQ-005 The block SHALL have parameter EXC_VECTOR, default 32'h000000FC, meaning PC loaded on exception.
REQ-006 The block SHALL have parameter CNT_W, default 16, meaning redirect counter width.
REQ-007 The block SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-008 The block SHALL have port reset, input, 1, meaning synchronous active-low reset.
REQ-009 The block SHALL have port selector, input, SEL_W, meaning source index.
REQ-010 The block SHALL have port data_in, input, NUM_SRC*DATA_W, meaning flattened sources; source k = data_in[k*DATA_W +: DATA_W].
REQ-011 The block SHALL have port pc_write, input, 1, meaning unconditional update request.
REQ-012 The block SHALL have ports pc_write_cond and cond_true, input, 1 each, meaning conditional update request and branch condition.
REQ-013 The block SHALL have port stall, input, 1, meaning the PC must not change except by exception.
REQ-014 The block SHALL have port exception, input, 1, meaning redirect to EXC_VECTOR.
REQ-015 The block SHALL have port pc_out, output, DATA_W, meaning the registered PC.
REQ-016 The block SHALL have port pc_next, output, DATA_W, meaning the combinational selected target.
REQ-017 The block SHALL have ports pending, sel_error and misaligned, output, 1 each, meaning buffered redirect held, registered bad-selector pulse, and pc_out[1:0] != 0.
REQ-018 The block SHALL have port redirect_count, output, CNT_W, meaning number of PC loads since reset.

Function
REQ-019 pc_next SHALL equal source[selector] when selector < NUM_SRC, else pc_out.
REQ-020 Update request upd SHALL be pc_write | (pc_write_cond & cond_true); pc_write_cond with cond_true=0 is no request.
REQ-021 The FSM SHALL have two states: IDLE (no buffered target) and PEND (target held in buf); pending=1 exactly in PEND.
REQ-022 Per-edge priority SHALL be: exception > new upd > buffered target.
REQ-023 In any state, exception=1 SHALL load pc_out<=EXC_VECTOR, discard buf, go IDLE.
REQ-024 In IDLE, upd & valid selector & !stall SHALL load pc_out<=pc_next (1-cycle latency, visible next edge).
REQ-025 In IDLE, upd & valid selector & stall SHALL capture buf<=pc_next, pc_out held, go PEND.
REQ-026 In PEND, stall=1 SHALL hold pc_out; upd with valid selector SHALL overwrite buf (newest wins).
REQ-027 In PEND, stall=0 SHALL load pc_out<=(upd & valid selector ? pc_next : buf) and go IDLE.
REQ-028 upd with selector >= NUM_SRC SHALL leave pc_out, buf and state unchanged and set sel_error=1 for exactly the next cycle.
REQ-029 redirect_count SHALL increment by 1 on every edge that loads pc_out (including exception) and saturate at all-ones.
REQ-030 misaligned SHALL be combinational from pc_out; it never blocks a load.
REQ-031 With no upd, no exception and IDLE, pc_out SHALL hold indefinitely.

Reset
REQ-032 On a rising edge with reset=0: pc_out=RESET_PC, buf=0, state=IDLE, pending=0, sel_error=0, redirect_count=0; reset overrides all other inputs.
REQ-033 Reset asserted while in PEND SHALL discard the buffered target; no load occurs after reset release.

Verification
REQ-034 Reset, then selector=2, source2=0x40, pc_write=1 one cycle -> pc_out=0x40 next edge, redirect_count=1.
REQ-035 pc_write_cond=1, cond_true=0, selector=1 -> pc_out unchanged, count unchanged; with cond_true=1 -> pc_out=source1.
REQ-036 stall=1, pc_write selector=0 (0x10) -> pending=1, pc_out held; second pc_write selector=3 (0x30) under stall; stall=0 -> pc_out=0x30, pending=0.
REQ-037 In PEND, exception=1 together with pc_write -> pc_out=0xFC, pending=0, buffered target never applied.
REQ-038 pc_write with selector=7 (NUM_SRC=5) -> pc_out held, sel_error=1 for one cycle, pc_next=pc_out.
REQ-039 CNT_W=2, five loads -> redirect_count=3; reset=0 mid-PEND -> pc_out=RESET_PC, pending=0, count=0.
